// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option: DM_ARB_RR_EN selects round-robin instead of fixed priority.
package dm_arb_pkg;

   localparam int DM_ADDR_W = 10;
   localparam int DM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef struct packed {
      logic                 wr;
      logic [DM_ADDR_W-1:0] addr;
      logic [DM_DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select for the two memory ports.
// DM_ARB_RR_EN defined: round-robin on contention; else port 0 wins.
module dm_arb_pick (
   input  logic valid0,
   input  logic valid1,
`ifdef DM_ARB_RR_EN
   input  logic last_grant,
`endif
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = valid0 | valid1;
      gnt_id    = 1'b0;
      unique case (1'b1)
         (valid0 && valid1): begin
`ifdef DM_ARB_RR_EN
            gnt_id = ~last_grant;
`else
            gnt_id = 1'b0;
`endif
         end
         (valid1 && !valid0): gnt_id = 1'b1;
         default:             gnt_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the 1024x32 data memory.
// DM_ARB_RR_EN defined: round-robin grant; undefined: port 0 priority.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_valid,
   input  logic              p0_wr,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_valid,
   input  logic              p1_wr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_datain,
   output logic              mem_memwr,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t state;
   req_t   sel;
   logic   gnt;
   logic   req_wr;
   logic   gnt_valid;
   logic   gnt_id;

`ifdef DM_ARB_RR_EN
   logic   last_grant;
`endif

   dm_arb_pick u_pick (
      .valid0     (p0_valid),
      .valid1     (p1_valid),
`ifdef DM_ARB_RR_EN
      .last_grant (last_grant),
`endif
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      sel = '0;
      if (gnt_id) begin
         sel.wr    = p1_wr;
         sel.addr  = p1_addr;
         sel.wdata = p1_wdata;
      end else begin
         sel.wr    = p0_wr;
         sel.addr  = p0_addr;
         sel.wdata = p0_wdata;
      end
   end

   // mem_addr/mem_datain double as the latched request; they hold outside ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         req_wr     <= 1'b0;
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
         mem_addr   <= '0;
         mem_datain <= '0;
         mem_memwr  <= 1'b0;
`ifdef DM_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               p0_ack <= 1'b0;
               p1_ack <= 1'b0;
               if (gnt_valid) begin
                  gnt        <= gnt_id;
                  req_wr     <= sel.wr;
                  mem_addr   <= sel.addr;
                  mem_datain <= sel.wdata;
                  mem_memwr  <= sel.wr;
`ifdef DM_ARB_RR_EN
                  last_grant <= gnt_id;
`endif
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               mem_memwr <= 1'b0;
               if (!req_wr) begin
                  if (gnt) p1_rdata <= mem_dout;
                  else     p0_rdata <= mem_dout;
               end
               p0_ack <= ~gnt;
               p1_ack <= gnt;
               state  <= RESP;
            end
            RESP: begin
               p0_ack <= 1'b0;
               p1_ack <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               mem_memwr <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1024x32 memory.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        p0_valid, p0_wr, p1_valid, p1_wr;
   logic [9:0]  p0_addr, p1_addr, mem_addr;
   logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic        p0_ack, p1_ack, mem_memwr;
   logic [31:0] mem_datain, mem_dout;

   logic [31:0] mem [1024] = '{default: 32'h0};

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr];

   always @(posedge clk) if (mem_memwr) mem[mem_addr] <= mem_datain;

   dm_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p0_valid   (p0_valid),
      .p0_wr      (p0_wr),
      .p0_addr    (p0_addr),
      .p0_wdata   (p0_wdata),
      .p0_ack     (p0_ack),
      .p0_rdata   (p0_rdata),
      .p1_valid   (p1_valid),
      .p1_wr      (p1_wr),
      .p1_addr    (p1_addr),
      .p1_wdata   (p1_wdata),
      .p1_ack     (p1_ack),
      .p1_rdata   (p1_rdata),
      .mem_addr   (mem_addr),
      .mem_datain (mem_datain),
      .mem_memwr  (mem_memwr),
      .mem_dout   (mem_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      vecs++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // one request, bounded wait for its ack; ends with the FSM back in IDLE
   task automatic req(input int port, input logic wr, input logic [9:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output int lat, output int nwr);
      lat = -1;
      nwr = 0;
      rd  = 32'hx;
      if (port == 0) begin
         p0_valid = 1'b1; p0_wr = wr; p0_addr = a; p0_wdata = d;
      end else begin
         p1_valid = 1'b1; p1_wr = wr; p1_addr = a; p1_wdata = d;
      end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_memwr) nwr++;
         if (port == 0 && p0_ack) begin
            lat = c; rd = p0_rdata; break;
         end
         if (port == 1 && p1_ack) begin
            lat = c; rd = p1_rdata; break;
         end
      end
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd, r0, r1, a0;
      logic [3:0]  seq, exp_seq;
      int          lat, nwr, t0, t1, n, bad, ta, tb2;

      p0_valid = 0; p0_wr = 0; p0_addr = 0; p0_wdata = 0;
      p1_valid = 0; p1_wr = 0; p1_addr = 0; p1_wdata = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_memwr", {31'b0, mem_memwr}, 32'h0);
      chk("rst_addr", {22'b0, mem_addr}, 32'h0);
      chk("rst_datain", mem_datain, 32'h0);
      chk("rst_acks", {30'b0, p1_ack, p0_ack}, 32'h0);
      chk("rst_rdata0", p0_rdata, 32'h0);
      chk("rst_rdata1", p1_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // write then read back through port 0
      req(0, 1'b1, 10'h005, 32'hDEADBEEF, rd, lat, nwr);
      chk("t1_wr_lat", lat, 32'd2);
      chk("t1_wr_memwr_cycles", nwr, 32'd1);
      req(0, 1'b0, 10'h005, 32'h0, rd, lat, nwr);
      chk("t1_rd_lat", lat, 32'd2);
      chk("t1_rd_data", rd, 32'hDEADBEEF);
      chk("t1_rd_memwr_cycles", nwr, 32'd0);
      chk("t1_rdata_hold", p0_rdata, 32'hDEADBEEF);

      // preload; port 1 served last so round-robin favours port 0 next
      req(0, 1'b1, 10'h001, 32'h11111111, rd, lat, nwr);
      req(1, 1'b1, 10'h002, 32'h22222222, rd, lat, nwr);

      // simultaneous requests
      p0_valid = 1; p0_wr = 0; p0_addr = 10'h001;
      p1_valid = 1; p1_wr = 0; p1_addr = 10'h002;
      t0 = -1; t1 = -1; r0 = 0; r1 = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (p0_ack) begin t0 = c; r0 = p0_rdata; p0_valid = 0; end
         if (p1_ack) begin t1 = c; r1 = p1_rdata; p1_valid = 0; end
         if (t0 > 0 && t1 > 0) break;
      end
      p0_valid = 0; p1_valid = 0;
      @(negedge clk);
      chk("t2_p0_ack_cycle", t0, 32'd2);
      chk("t2_p1_ack_cycle", t1, 32'd5);
      chk("t2_p0_data", r0, 32'h11111111);
      chk("t2_p1_data", r1, 32'h22222222);

      // both ports requesting continuously
      p0_valid = 1; p0_wr = 0; p0_addr = 10'h001;
      p1_valid = 1; p1_wr = 0; p1_addr = 10'h002;
      seq = 4'b0; n = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (p0_ack || p1_ack) begin
            if (n < 4) seq[n] = p1_ack;
            n++;
         end
      end
      p0_valid = 0; p1_valid = 0;
      @(negedge clk);
`ifdef DM_ARB_RR_EN
      exp_seq = 4'b1010;
`else
      exp_seq = 4'b0000;
`endif
      chk("t2_contend_acks", n, 32'd4);
      chk("t2_contend_order", {28'b0, seq}, {28'b0, exp_seq});

      // top address, no aliasing onto word 0
      req(1, 1'b1, 10'h3FF, 32'h12345678, rd, lat, nwr);
      req(1, 1'b0, 10'h3FF, 32'h0, rd, lat, nwr);
      chk("t3_top_data", rd, 32'h12345678);
      chk("t3_top_lat", lat, 32'd2);
      req(1, 1'b1, 10'h3FE, 32'hCAFEF00D, rd, lat, nwr);
      chk("t3_wr_keeps_rdata", p1_rdata, 32'h12345678);
      req(1, 1'b0, 10'h000, 32'h0, rd, lat, nwr);
      chk("t3_addr0_data", rd, 32'h0);

      // reset while a write is in ACCESS
      p0_valid = 1; p0_wr = 1; p0_addr = 10'h010; p0_wdata = 32'hAAAA5555;
      @(negedge clk);
      chk("t4_memwr_in_access", {31'b0, mem_memwr}, 32'h1);
      #1 rst_n = 1'b0;
      #1 chk("t4_memwr_async_drop", {31'b0, mem_memwr}, 32'h0);
      p0_valid = 0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (p0_ack || p1_ack) bad++;
      end
      chk("t4_no_ack", bad, 32'd0);
      chk("t4_rdata_cleared", p0_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      req(0, 1'b0, 10'h010, 32'h0, rd, lat, nwr);
      chk("t4_write_abandoned", rd, 32'h0);

      // valid held across RESP
      p0_valid = 1; p0_wr = 0; p0_addr = 10'h005;
      n = 0; ta = -1; tb2 = -1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (p0_ack) begin
            if (n == 0) ta = c;
            else tb2 = c;
            n++;
         end
      end
      p0_valid = 0;
      @(negedge clk);
      chk("t5_ack_count", n, 32'd2);
      chk("t5_first_ack", ta, 32'd2);
      chk("t5_second_ack", tb2, 32'd5);

      // idle bus
      a0 = {22'b0, mem_addr};
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_memwr || p0_ack || p1_ack || {22'b0, mem_addr} != a0) bad++;
      end
      chk("t6_idle_quiet", bad, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
